mul_issue_queue: RTL

- Issue buffer and sequencer sitting directly upstream of the radix-4 Booth multiply unit.
- Accepts MUL/MULH/MULHU/MULHSU requests from dispatch into a small FIFO and launches one request at a time.
- Drives the multiplier's operands, operation and clock enable, and holds them stable for the full iterative computation.
- Captures the result into a tagged output register with a valid/ready handshake toward writeback.

---
 rtl/mul_issue_queue.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mul_issue_queue.sv
// Issue queue and sequencer in front of the iterative radix-4 Booth multiplier:
// buffers requests, launches one at a time, holds operands, captures tagged results.
package mul_issue_queue_pkg;
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MUL_    = 2'd0,
        MULH_   = 2'd1,
        MULHU_  = 2'd2,
        MULHSU_ = 2'd3
    } mul_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;
endpackage

module mul_issue_queue #(
    parameter int unsigned XLEN       = mul_issue_queue_pkg::XLEN,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TAG_W      = 5,
    parameter int unsigned MUL_CYCLES = 17
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [XLEN-1:0]  in_op1_i,
    input  logic [XLEN-1:0]  in_op2_i,
    input  logic [1:0]       in_operation_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic [XLEN-1:0]  mul_multiplier_o,
    output logic [XLEN-1:0]  mul_multiplicand_o,
    output logic [1:0]       mul_operation_o,
    output logic             mul_clk_en_o,
    input  logic             mul_state_i,
    input  logic [XLEN-1:0]  mul_result_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_result_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             busy_o
);
    import mul_issue_queue_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned RUN_W = $clog2(MUL_CYCLES);

    typedef struct packed {
        logic [XLEN-1:0]  op1;
        logic [XLEN-1:0]  op2;
        mul_ops_e         op;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESULT = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    req_t             fifo_q [DEPTH];
    req_t             req_in;
    req_t             infl_q,       infl_d;
    state_e           state_q,      state_d;
    logic [RUN_W-1:0] run_cnt_q,    run_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0] count_q,      count_d;
    logic             out_valid_q,  out_valid_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q,    out_tag_d;
    logic             clk_en_q,     clk_en_d;
    logic             in_ready_q,   in_ready_d;
    logic             busy_q,       busy_d;

    logic push;
    logic pop;
    logic capture;
    logic run_last;

    // Handshake qualifiers; flush suppresses every one of them.
    always_comb begin
        req_in   = '{op1: in_op1_i, op2: in_op2_i,
                     op: mul_ops_e'(in_operation_i), tag: in_tag_i};
        push     = in_valid_i & in_ready_q & ~flush_i;
        pop      = (state_q == IDLE) & (count_q != '0) & ~flush_i;
        run_last = (run_cnt_q == RUN_W'(MUL_CYCLES - 1));
        capture  = (state_q == RESULT) & (fu_state_e'(mul_state_i) == FREE)
                 & (~out_valid_q | out_ready_i) & ~flush_i;
    end

    // Next-state logic for queue, sequencer and output register.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        state_d      = state_q;
        run_cnt_d    = run_cnt_q;
        infl_d       = infl_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    infl_d    = fifo_q[rd_ptr_q];
                    run_cnt_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Counter keeps tracking the multiplier even across a flush.
                run_cnt_d = run_last ? '0 : run_cnt_q + RUN_W'(1);
                if (run_last) begin
                    state_d = flush_i ? IDLE : RESULT;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                run_cnt_d = run_last ? '0 : run_cnt_q + RUN_W'(1);
                if (run_last) begin
                    state_d = IDLE;
                end
            end
            RESULT: begin
                if (flush_i || capture) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d  = 1'b1;
            out_result_d = mul_result_i;
            out_tag_d    = infl_q.tag;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end

        clk_en_d   = (state_d == RUN) | (state_d == DRAIN);
        in_ready_d = (count_d != CNT_W'(DEPTH)) & (state_d != DRAIN);
        busy_d     = (count_d != '0) | (state_d != IDLE) | out_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            run_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            infl_q       <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            clk_en_q     <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            infl_q       <= infl_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            clk_en_q     <= clk_en_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Queue storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= req_in;
        end
    end

    assign in_ready_o         = in_ready_q;
    assign mul_multiplier_o   = infl_q.op1;
    assign mul_multiplicand_o = infl_q.op2;
    assign mul_operation_o    = infl_q.op;
    assign mul_clk_en_o       = clk_en_q;
    assign out_valid_o        = out_valid_q;
    assign out_result_o       = out_result_q;
    assign out_tag_o          = out_tag_q;
    assign busy_o             = busy_q;

    // Sequencer and multiplier counter must agree whenever a result is awaited.
    a_result_free: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == RESULT) |-> (fu_state_e'(mul_state_i) == FREE));
    a_idle_no_clk: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == IDLE) |-> !clk_en_q);
    a_count_range: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CNT_W'(DEPTH));

endmodule
